aes_core_scheduler: RTL
=======================

# aes_core_scheduler

- Shares one AES-128 core among `N_REQ` requesters using round-robin arbitration.
- Runs one job at a time. A job is one 128-bit block, encrypted or decrypted under a 128-bit key.
- Drives the core's start, key-change and cipher-select controls, and tracks which key is currently expanded in the core's round-key bank so key expansion is skipped when the same key is reused.
- Sits between the bus-side requester ports and the AES core controller.

## Interface
- `N_REQ`, default 2: number of requesters, 2..4.
- `BLK_W`, default 128: data and key width. Fixed at 128; present for readability only.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: job request per requester.
- `req_ready` out N_REQ: job accepted on `req_valid & req_ready`.
- `req_decrypt` in N_REQ: 1 = decrypt, 0 = encrypt.
- `req_key` in N_REQ×128: job key.
- `req_data` in N_REQ×128: job input block.
- `resp_valid` out N_REQ: result available for the owning requester.
- `resp_ready` in N_REQ: result consumed on `resp_valid & resp_ready`.
- `resp_data` out 128: result block, shared by all requesters.
- `key_invalidate` in 1: forces re-expansion on the next job.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_key_change` out 1: core must expand the key before the cipher runs. Valid with `core_start`.
- `core_sel_cypher` out 1: 1 = encrypt, 0 = decrypt. Valid with `core_start`.
- `core_key` out 128: registered job key, held stable from ISSUE to the end of WAIT.
- `core_data` out 128: registered job block, held stable from ISSUE to the end of WAIT.
- `core_done` in 1: one-cycle pulse; `core_result` is valid in that cycle.
- `core_result` in 128: core output block.
- `jobs_done` out 16: count of completed jobs; wraps.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - The arbiter grants the first requester with `req_valid` set, searching from `rr_ptr` upward modulo N_REQ.
  - Only the granted requester sees `req_ready = 1`.
  - On handshake: latch key, data, decrypt flag and owner index; go to ISSUE.
- **ISSUE**
  - `core_start = 1` for exactly one cycle.
  - `core_sel_cypher = ~decrypt`.
  - `core_key_change = ~key_valid | (job_key != loaded_key)`. This value is latched as `kc_issued`.
  - Go to WAIT.
- **WAIT**
  - Wait for `core_done`.
  - On `core_done`: capture `core_result` into `resp_data` and increment `jobs_done`.
  - If `kc_issued`, set `loaded_key <= job_key` and `key_valid <= 1`.
  - Go to RESP.
- **RESP**
  - `resp_valid[owner] = 1`.
  - On `resp_ready[owner]`: set `rr_ptr <= owner + 1` (mod N_REQ) and go to IDLE.

Boundary rules:
- **Reset values:** all outputs are 0, `rr_ptr = 0`, `key_valid = 0`, `jobs_done = 0`, state is IDLE.
- **`key_invalidate`:** clears `key_valid` in any state.
  - If it coincides with a WAIT `core_done` that would set `key_valid`, the invalidate wins.
  - If it is asserted during ISSUE, the `core_key_change` already issued is not changed.
- **Stray `core_done`:** a `core_done` outside WAIT is ignored.
- **Unconnected `resp_ready`:** `resp_ready` of non-owner requesters is ignored.
- **Dropped requests:** a requester that drops `req_valid` before being granted loses nothing and is not recorded.
- **Counter wrap:** `jobs_done` wraps from 0xFFFF to 0.
- **Reset mid-job:** the job is discarded and no response is issued. The core shares `reset`.
- **Illegal state encodings:** recover to IDLE.

## Timing
- Handshake at edge E0, `core_start` high in cycle E0+1. Core latency L cycles from start to `core_done`.
- `resp_valid` rises one cycle after `core_done`.
- With `resp_ready` held at 1: `resp_valid` is high one cycle, and the next `req_ready` can assert in the following cycle.
- Minimum overhead is 3 cycles per job plus L.
- All outputs are registered except `req_ready`, which is decoded from state and the arbiter grant.

## Configuration
- `AES_SCHED_KEY_CACHE_EN` defined: key tracking operates as described above.
- Undefined:
  - The `loaded_key`/`key_valid` registers and the 128-bit comparator are not built.
  - `core_key_change = 1` on every `core_start`.
  - `key_invalidate` is ignored.

## Structure
- Package `aes_pkg` holds:
  - `sched_state_t` (IDLE, ISSUE, WAIT, RESP)
  - `AES_BLK_W = 128`
  - `AES_MAX_REQ = 4`
- Sub-module `rr_arbiter`, parameterised by `N_REQ`:
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant` and `grant_idx`.
  - Purely combinational.

## Test plan
1. **Single encrypt with cold cache:** after reset, requester 0 sends key K1, encrypt. Expect `core_start` with `core_key_change = 1`, `core_sel_cypher = 1`; `resp_valid[0]` asserts one cycle after `core_done`; `jobs_done = 1`.
2. **Key reuse:** requester 0 sends K1 again, then K2. Expect `core_key_change = 0` for the K1 job and 1 for the K2 job. With the macro undefined, expect 1 both times.
3. **Round-robin fairness:** requesters 0 and 1 hold `req_valid` continuously. Grants alternate 0, 1, 0, 1; `rr_ptr` follows.
4. **Invalidate race:** `key_invalidate` in the same cycle as a `core_done` that would load K1. Next job with K1 expects `core_key_change = 1`.
5. **Response backpressure:** hold `resp_ready = 0` for 10 cycles. `resp_valid` and `resp_data` stay stable and `req_ready` stays 0 throughout.
6. **Reset in WAIT:** assert `reset` while in WAIT. All outputs return to 0, no `resp_valid` is ever issued for that job, and a stray `core_done` afterwards is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and scheduler state encoding for aes_core_scheduler.
// States are plain 2-bit constants so legacy code can compare them directly.
package aes_pkg;

    localparam int unsigned AES_BLK_W   = 128;
    localparam int unsigned AES_MAX_REQ = 4;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t IDLE  = 2'd0;
    localparam sched_state_t ISSUE = 2'd1;
    localparam sched_state_t WAIT  = 2'd2;
    localparam sched_state_t RESP  = 2'd3;

    // Index width for an N-entry requester vector; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found
// searching upward from ptr, wrapping modulo N_REQ.
module rr_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES-128 core among N_REQ requesters.
// Define AES_SCHED_KEY_CACHE_EN to skip key expansion when the loaded key is reused.
module aes_core_scheduler
    import aes_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned BLK_W = AES_BLK_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_decrypt,
    input  logic [N_REQ*BLK_W-1:0] req_key,
    input  logic [N_REQ*BLK_W-1:0] req_data,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [BLK_W-1:0]       resp_data,
    input  logic                   key_invalidate,
    output logic                   core_start,
    output logic                   core_key_change,
    output logic                   core_sel_cypher,
    output logic [BLK_W-1:0]       core_key,
    output logic [BLK_W-1:0]       core_data,
    input  logic                   core_done,
    input  logic [BLK_W-1:0]       core_result,
    output logic [15:0]            jobs_done
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, owner_q, grant_idx;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] resp_valid_q;
    logic [BLK_W-1:0] resp_data_q, core_key_q, core_data_q;
    logic [BLK_W-1:0] sel_key, sel_data;
    logic             core_start_q, core_kc_q, core_sel_q;
    logic [15:0]      jobs_done_q;
    logic             handshake, kc_next, done_in_wait;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign handshake    = |(req_valid & req_ready);
    assign sel_key      = req_key[32'(grant_idx)*BLK_W +: BLK_W];
    assign sel_data     = req_data[32'(grant_idx)*BLK_W +: BLK_W];
    assign done_in_wait = (state_q == WAIT) && core_done;

`ifdef AES_SCHED_KEY_CACHE_EN
    logic [BLK_W-1:0] loaded_key_q;
    logic             key_valid_q;

    // An invalidate seen at handshake already forces expansion of that job.
    assign kc_next = ~key_valid_q | key_invalidate | (sel_key != loaded_key_q);

    // core_kc_q doubles as kc_issued; invalidate outranks a same-cycle load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_key_q <= '0;
            key_valid_q  <= 1'b0;
        end else if (key_invalidate) begin
            key_valid_q  <= 1'b0;
        end else if (done_in_wait && core_kc_q) begin
            loaded_key_q <= core_key_q;
            key_valid_q  <= 1'b1;
        end
    end
`else
    logic unused_key_invalidate;

    assign kc_next               = 1'b1;
    assign unused_key_invalidate = key_invalidate;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake)           state_d = ISSUE;
            ISSUE:                            state_d = WAIT;
            WAIT:    if (core_done)           state_d = RESP;
            RESP:    if (resp_ready[owner_q]) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            core_start_q <= 1'b0;
            core_kc_q    <= 1'b0;
            core_sel_q   <= 1'b0;
            core_key_q   <= '0;
            core_data_q  <= '0;
            jobs_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: if (handshake) begin
                    owner_q      <= grant_idx;
                    core_key_q   <= sel_key;
                    core_data_q  <= sel_data;
                    core_start_q <= 1'b1;
                    core_kc_q    <= kc_next;
                    core_sel_q   <= ~req_decrypt[grant_idx];
                end
                WAIT: if (core_done) begin
                    resp_data_q           <= core_result;
                    jobs_done_q           <= jobs_done_q + 16'd1;
                    resp_valid_q[owner_q] <= 1'b1;
                end
                RESP: if (resp_ready[owner_q]) begin
                    resp_valid_q <= '0;
                    rr_ptr_q     <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign core_start      = core_start_q;
    assign core_key_change = core_kc_q;
    assign core_sel_cypher = core_sel_q;
    assign core_key        = core_key_q;
    assign core_data       = core_data_q;
    assign jobs_done       = jobs_done_q;

endmodule
